// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder
//   Data-memory target for the MIPS core's load/store port. Requests are
//   accepted in IDLE, held for WAIT_STATES cycles in WAIT, and answered with a
//   one-cycle mem_ready strobe in RESP. Behind the port sit a word RAM, an
//   output FIFO at 0xFFFF_0000, a status word at 0xFFFF_0004 and, when
//   DMEM_CYCLE_COUNTER_EN is defined, a free-running cycle counter at
//   0xFFFF_0008. Unmapped loads return 0xDEAD_BEEF.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   mem_req/mem_we/mem_addr/mem_wdata   core request (held until mem_ready)
//   mem_rdata/mem_ready        registered response, one cycle wide
//   out_valid/out_data/out_ready        output FIFO head and pop handshake
// Optional feature macro: DMEM_CYCLE_COUNTER_EN
module mips_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);

  // Word addresses (byte address >> 2)
  localparam logic [29:0] WA_OUT    = 30'h3FFF_C000;
  localparam logic [29:0] WA_STATUS = 30'h3FFF_C001;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [29:0] WA_CYC    = 30'h3FFF_C002;
`endif
  localparam logic [31:0] UNMAPPED  = 32'hDEAD_BEEF;
  localparam logic [FW:0] FULL_CNT  = (FW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic        req_we;
  logic [29:0] req_wa;
  logic [31:0] req_wdata;
  logic [3:0]  wcnt;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic          fifo_full, fifo_empty, push, pop;

  logic        sel_we;
  logic [29:0] sel_wa;
  logic        stall;
  logic [31:0] rd_next;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  logic        cyc_clear;
  assign cyc_clear = (state == S_RESP) && req_we && (req_wa == WA_CYC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycles <= '0;
    else if (cyc_clear) cycles <= '0;
    else                cycles <= cycles + 32'd1;
  end
`endif

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];

  assign push = (state == S_RESP) && req_we && (req_wa == WA_OUT) && !fifo_full;
  assign pop  = out_ready && !fifo_empty;

  // Response data and the backpressure decision are formed on the edge that
  // enters RESP. With WAIT_STATES=0 that edge is the accepting edge itself,
  // so the live request is used in IDLE and the registered copy afterwards.
  assign sel_we = (state == S_IDLE) ? mem_we : req_we;
  assign sel_wa = (state == S_IDLE) ? mem_addr[31:2] : req_wa;
  assign stall  = sel_we && (sel_wa == WA_OUT) && fifo_full;

  always_comb begin
    rd_next = UNMAPPED;
    if (sel_wa[29:AW] == '0)       rd_next = ram[sel_wa[AW-1:0]];
    else if (sel_wa == WA_OUT)     rd_next = '0;
    else if (sel_wa == WA_STATUS)  rd_next = {30'b0, fifo_full, fifo_empty};
`ifdef DMEM_CYCLE_COUNTER_EN
    // value the counter holds once RESP has been entered
    else if (sel_wa == WA_CYC)     rd_next = cycles + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      req_we    <= 1'b0;
      req_wa    <= '0;
      req_wdata <= '0;
      wcnt      <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            req_we    <= mem_we;
            req_wa    <= mem_addr[31:2];
            req_wdata <= mem_wdata;
            if (WS != 4'd0 || stall) begin
              state <= S_WAIT;
              wcnt  <= WS;
            end else begin
              state     <= S_RESP;
              mem_ready <= 1'b1;
              mem_rdata <= rd_next;
            end
          end
        end
        S_WAIT: begin
          if (wcnt > 4'd1) begin
            wcnt <= wcnt - 4'd1;
          end else if (!stall) begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            mem_rdata <= rd_next;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && req_we && (req_wa[29:AW] == '0))
      ram[req_wa[AW-1:0]] <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
